// File: rtl/mem_arb_pkg.sv
// Shared types and the round-robin selection helper for the memory read arbiter.
// Types are sized for the largest supported client count (8).
package mem_arb_pkg;

    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] index;
    } pick_t;

    // First set bit of valid_vec scanning upward from last+1, wrapping at num.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0]  valid_vec,
        input logic [MAX_ID_W-1:0] last,
        input logic [MAX_ID_W:0]   num
    );
        pick_t                 p;
        logic [MAX_ID_W:0]     idx;
        p = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = {1'b0, last} + (MAX_ID_W+1)'(k);
            if (idx >= num) begin
                idx = idx - num;
            end
            if (((MAX_ID_W+1)'(k) <= num) && !p.found && valid_vec[idx[MAX_ID_W-1:0]]) begin
                p.found = 1'b1;
                p.index = idx[MAX_ID_W-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: candidate selection, hold gating, next pointer.
// The candidate is exposed before gating so the caller can derive the hold.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ID_WIDTH = 1
) (
    input  logic [NUM_REQ-1:0]  i_req_valid,
    input  logic                i_hold,
    input  logic [ID_WIDTH-1:0] i_last,
    output logic                o_found,
    output logic [ID_WIDTH-1:0] o_cand,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [ID_WIDTH-1:0] o_next_last
);

    logic [MAX_REQ-1:0]  w_valid_pad;
    logic [MAX_ID_W-1:0] w_last_pad;
    pick_t               w_pick;
    logic                w_take;

    always_comb begin
        w_valid_pad = '0;
        w_valid_pad[NUM_REQ-1:0] = i_req_valid;
        w_last_pad = '0;
        w_last_pad[ID_WIDTH-1:0] = i_last;
    end

    assign w_pick  = rr_pick(w_valid_pad, w_last_pad, (MAX_ID_W+1)'(NUM_REQ));
    assign o_found = w_pick.found;
    assign o_cand  = w_pick.index[ID_WIDTH-1:0];
    assign w_take  = w_pick.found && !i_hold;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign o_grant[gi] = w_take && (w_pick.index == MAX_ID_W'(gi));
        end
    endgenerate

    // A held candidate keeps its priority: the pointer does not move.
    assign o_next_last = w_take ? o_cand : i_last;

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin sharing of one latency-memory read port among NUM_REQ clients,
// with same-cycle write collision hold and tag-based response routing.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_LAT   = 2,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [ADDR_WIDTH-1:0]         mem_r_addr,
    output logic                          mem_r_avalid,
    input  logic                          mem_r_dvalid,
    input  logic [DATA_WIDTH-1:0]         mem_r_data,
    input  logic [ADDR_WIDTH-1:0]         mem_w_addr,
    input  logic                          mem_w_valid,
    output logic                          err_tag
);

    logic [ID_WIDTH-1:0]   r_last;
    tag_t                  r_tag [DATA_LAT];
    logic                  r_err;

    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_cand;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_WIDTH-1:0]   w_next_last;
    logic [ADDR_WIDTH-1:0] w_cand_addr;
    logic                  w_hazard;
    tag_t                  w_tag_in;
    tag_t                  w_tag_out;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .i_req_valid (req_valid),
        .i_hold      (w_hazard),
        .i_last      (r_last),
        .o_found     (w_found),
        .o_cand      (w_cand),
        .o_grant     (w_grant),
        .o_next_last (w_next_last)
    );

    always_comb begin
        w_cand_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_cand == ID_WIDTH'(i)) begin
                w_cand_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // The memory does not forward writes, so a same-address read must wait a cycle.
    assign w_hazard     = mem_w_valid && w_found && (mem_w_addr == w_cand_addr);
    assign req_ready    = rst ? '0 : w_grant;
    assign mem_r_avalid = |req_ready;
    assign mem_r_addr   = w_cand_addr;

    always_comb begin
        w_tag_in = '0;
        w_tag_in.valid = mem_r_avalid;
        w_tag_in.id[ID_WIDTH-1:0] = w_cand;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= ID_WIDTH'(NUM_REQ - 1);
            r_err  <= 1'b0;
            for (int i = 0; i < DATA_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_last   <= w_next_last;
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < DATA_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (mem_r_dvalid != r_tag[DATA_LAT-1].valid) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_tag_out = r_tag[DATA_LAT-1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_resp
            assign resp_valid[gi] = !rst && mem_r_dvalid && w_tag_out.valid
                                    && (w_tag_out.id == MAX_ID_W'(gi));
        end
    endgenerate

    assign resp_data = mem_r_data;
    assign err_tag   = r_err;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench: a reference arbiter pushes expected responses, a monitor pops
// and checks them on the due cycle; a behavioural latency memory sits on the ports.
module tb_mem_read_arbiter;

    localparam int N   = 2;
    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;
    logic [AW-1:0]   mem_r_addr;
    logic            mem_r_avalid;
    logic            mem_r_dvalid;
    logic [DW-1:0]   mem_r_data;
    logic [AW-1:0]   mem_w_addr;
    logic            mem_w_valid;
    logic            err_tag;
    logic [DW-1:0]   w_data;
    logic            force_dv;

    always #5 clk = ~clk;

    mem_read_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DATA_LAT   (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .mem_r_addr   (mem_r_addr),
        .mem_r_avalid (mem_r_avalid),
        .mem_r_dvalid (mem_r_dvalid),
        .mem_r_data   (mem_r_data),
        .mem_w_addr   (mem_w_addr),
        .mem_w_valid  (mem_w_valid),
        .err_tag      (err_tag)
    );

    // Behavioural memory: read sampled at the request edge, data LAT cycles later.
    logic [DW-1:0] mem [16];
    logic          pv  [LAT];
    logic [DW-1:0] pd  [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= mem_r_avalid;
            pd[0] <= mem[mem_r_addr];
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
        if (mem_w_valid) mem[mem_w_addr] <= w_data;
    end

    assign mem_r_dvalid = pv[LAT-1] | force_dv;
    assign mem_r_data   = pd[LAT-1];

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    int            m_last;
    logic [N-1:0]  m_grant;
    logic [DW-1:0] ref_mem [16];
    bit            a_found;
    int            a_cand;
    logic [AW-1:0] a_addr;
    logic [N-1:0]  a_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and reference arbiter, both evaluated mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_avalid", mem_r_avalid, 0);
            chk("rst_resp", resp_valid, 0);
            q.delete();
            m_last  = N - 1;
            m_grant = '0;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("resp_valid", resp_valid, (N'(1) << e.id));
                chk("resp_data", resp_data, e.data);
            end else begin
                chk("no_resp", resp_valid, 0);
            end
            a_found = 0;
            a_cand  = 0;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (!a_found && req_valid[idx]) begin
                    a_found = 1;
                    a_cand  = idx;
                end
            end
            a_addr = req_addr[a_cand*AW +: AW];
            a_exp  = '0;
            if (a_found && !(mem_w_valid && mem_w_addr == a_addr)) a_exp = N'(1) << a_cand;
            chk("grant", req_ready, a_exp);
            chk("avalid", mem_r_avalid, (a_exp != 0));
            if (a_exp != 0) begin
                chk("r_addr", mem_r_addr, a_addr);
                q.push_back('{id: a_cand, data: ref_mem[a_addr], due: cyc + LAT});
                m_last = a_cand;
            end
            m_grant = a_exp;
        end
        if (mem_w_valid) ref_mem[mem_w_addr] = w_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; mem_w_addr = '0;
        mem_w_valid = 1'b0; w_data = '0; force_dv = 1'b0;
        m_last = N - 1; m_grant = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     <= 32'hA5A5_0000 | DW'(i);
            ref_mem[i]  = 32'hA5A5_0000 | DW'(i);
        end
        repeat (3) step();
        chk("rst_err", err_tag, 0);
        rst = 1'b0;
        step();

        // Single read from client 1, address 3.
        req_valid = 2'b10; req_addr[AW +: AW] = 4'd3;
        @(negedge clk);
        chk("single_grant", req_ready, 2'b10);
        step();
        req_valid = '0;
        repeat (3) step();

        // Both clients continuously valid for six cycles.
        req_valid = 2'b11; req_addr[0 +: AW] = 4'd1; req_addr[AW +: AW] = 4'd2;
        repeat (6) step();
        req_valid = '0;
        repeat (3) step();

        // Same-cycle write to the candidate's address holds the read one cycle.
        req_valid = 2'b01; req_addr[0 +: AW] = 4'd5;
        mem_w_valid = 1'b1; mem_w_addr = 4'd5; w_data = 32'h0000_1234;
        @(negedge clk);
        chk("hazard_hold", req_ready, 2'b00);
        step();
        mem_w_valid = 1'b0;
        @(negedge clk);
        chk("hazard_grant", req_ready, 2'b01);
        step();
        req_valid = '0;
        repeat (3) step();

        // Write to a different address does not stall.
        req_valid = 2'b01; req_addr[0 +: AW] = 4'd5;
        mem_w_valid = 1'b1; mem_w_addr = 4'd6; w_data = $urandom;
        @(negedge clk);
        chk("nocollide_grant", req_ready, 2'b01);
        step();
        req_valid = '0; mem_w_valid = 1'b0;
        repeat (3) step();

        // Randomized traffic with colliding writes over a small address range.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !m_grant[i])) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
                end
            end
            mem_w_valid = ($urandom_range(0, 2) == 0);
            mem_w_addr  = AW'($urandom_range(0, 3));
            w_data      = $urandom;
            step();
        end
        req_valid = '0; mem_w_valid = 1'b0;
        repeat (LAT + 2) step();
        chk("err_clean", err_tag, 0);

        // Reset one cycle after a grant: in-flight read is discarded.
        req_valid = 2'b01; req_addr[0 +: AW] = 4'd2;
        step();
        req_valid = '0; rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 2'b11; req_addr[0 +: AW] = 4'd1; req_addr[AW +: AW] = 4'd2;
        @(negedge clk);
        chk("post_rst_first", req_ready, 2'b01);
        step();
        req_valid = '0;
        repeat (4) step();
        @(negedge clk);
        chk("post_rst_err", err_tag, 0);

        // Spurious read-data valid with an empty tag pipeline.
        step();
        force_dv = 1'b1;
        step();
        force_dv = 1'b0;
        @(negedge clk);
        chk("tag_err_set", err_tag, 1);
        repeat (3) step();
        @(negedge clk);
        chk("tag_err_sticky", err_tag, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("tag_err_clear", err_tag, 0);

        repeat (LAT + 2) step();
        chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
